// File: rtl/counter_monitor.sv
// Passive checker for the 4-bit universal counter: predicts the next count, flags mismatches,
// tallies errors and latches FAULT. Define MON_TC_EN to build the terminal-count (wrap) detector.
module counter_monitor #(
   parameter int unsigned BCD_MAX   = 9,
   parameter int unsigned ERR_LIMIT = 3,
   parameter int unsigned ECW       = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           pause,
   input  logic           mode,
   input  logic           incr,
   input  logic [3:0]     count,
   output logic           locked,
   output logic           err,
   output logic [ECW-1:0] err_cnt,
   output logic           fault,
   output logic           tc
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam logic [3:0] BCD_TOP = 4'(BCD_MAX);
   localparam logic [3:0] CEC_LIM = 4'(ERR_LIMIT);

   // Next value the counter should present, given its current output and controls.
   function automatic logic [3:0] predict(input logic [3:0] c,
                                          input logic       clr,
                                          input logic       pse,
                                          input logic       md,
                                          input logic       inc);
      if (clr)
         return 4'd0;
      else if (pse)
         return c;
      else if (!md)
         return inc ? c + 4'd1 : c - 4'd1;
      else if (inc)
         return (c >= BCD_TOP) ? 4'd0 : c + 4'd1;
      else
         return ((c == 4'd0) || (c > BCD_TOP)) ? BCD_TOP : c - 4'd1;
   endfunction

   state_t         state_q, state_d;
   logic [3:0]     exp_q;
   logic [3:0]     cec_q, cec_d;
   logic [ECW-1:0] err_cnt_q, err_cnt_d;
   logic           err_q, err_d;
   logic           prev_mode;
   logic           miss;

   // NOTE: every register below uses non-blocking assignment so all state updates
   // see the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNLOCKED;
         exp_q     <= 4'd0;
         cec_q     <= 4'd0;
         err_cnt_q <= '0;
         err_q     <= 1'b0;
         prev_mode <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= predict(count, clear, pause, mode, incr);
         cec_q     <= cec_d;
         err_cnt_q <= err_cnt_d;
         err_q     <= err_d;
         prev_mode <= mode;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cec_d     = cec_q;
      err_cnt_d = err_cnt_q;
      err_d     = 1'b0;
      miss      = (count != exp_q) || (prev_mode && (count > BCD_TOP));

      unique case (state_q)
         UNLOCKED: state_d = LOCKED;

         LOCKED: begin
            err_d = miss;
            // A sampled clear wipes the tally even when this edge's comparison fails.
            if (clear) begin
               cec_d     = 4'd0;
               err_cnt_d = '0;
            end else if (miss) begin
               if (err_cnt_q != '1)
                  err_cnt_d = err_cnt_q + ECW'(1);
               cec_d = cec_q + 4'd1;
               if ((cec_q + 4'd1) >= CEC_LIM)
                  state_d = FAULT;
            end else begin
               cec_d = 4'd0;
            end
         end

         FAULT: begin
            if (clear) begin
               state_d   = LOCKED;
               cec_d     = 4'd0;
               err_cnt_d = '0;
            end
         end

         default: state_d = UNLOCKED;
      endcase
   end

   assign locked  = (state_q == LOCKED);
   assign fault   = (state_q == FAULT);
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

`ifdef MON_TC_EN
   logic [3:0] prev_count;
   logic       prev_clear;
   logic       prev_pause;
   logic       prev_incr;
   logic [3:0] wrap_top;
   logic       wrap;
   logic       tc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_count <= 4'd0;
         prev_clear <= 1'b0;
         prev_pause <= 1'b0;
         prev_incr  <= 1'b0;
         tc_q       <= 1'b0;
      end else begin
         prev_count <= count;
         prev_clear <= clear;
         prev_pause <= pause;
         prev_incr  <= incr;
         tc_q       <= (state_q == LOCKED) && wrap;
      end
   end

   // Only a counted step in the sampled direction is a wrap; a clear to zero is not.
   always_comb begin
      wrap_top = prev_mode ? BCD_TOP : 4'hF;
      wrap     = 1'b0;
      if (!prev_clear && !prev_pause) begin
         if (prev_incr)
            wrap = (prev_count == wrap_top) && (count == 4'd0);
         else
            wrap = (prev_count == 4'd0) && (count == wrap_top);
      end
   end

   assign tc = tc_q;
`else
   assign tc = 1'b0;
`endif

endmodule
